euclidean_distance: RTL and testbench

Computes the squared Euclidean distance between one buffered feature vector and each of N_WORDS stored word templates, emitting one (word index, distance) result per template. Sits directly upstream of `euclidean_comparator`: `oword`/`odata`/`ovalid` drive its `iword`/`idata`/`ivalid`. Templates are read from an external synchronous ROM/BRAM; features arrive on a valid/ready stream from the feature extractor.

---
 rtl/euclidean_distance.sv | 177 +++++++++++++++++
 tb/tb_euclidean_distance.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/euclidean_distance.sv
// Squared Euclidean (or L1) distance between a buffered feature vector and N_WORDS ROM templates.
// Optional build macro EUCLID_MANHATTAN_EN selects |diff| instead of diff^2 (L1 distance).
module euclidean_distance #(
    parameter int N_WORDS = 10,
    parameter int N_FEAT  = 32,
    parameter int FEAT_W  = 16,
    parameter int ADDR_W  = $clog2(N_WORDS * N_FEAT)
) (
    input  logic                     iclk,
    input  logic                     irstn,
    input  logic signed [FEAT_W-1:0] ifeat,
    input  logic                     ifeat_valid,
    output logic                     ifeat_ready,
    input  logic                     istart,
    output logic [ADDR_W-1:0]        otmpl_addr,
    input  logic signed [FEAT_W-1:0] itmpl_data,
    output logic [3:0]               oword,
    output logic [63:0]              odata,
    output logic                     ovalid,
    output logic                     obusy,
    output logic                     odone
);
    localparam int F_W   = $clog2(N_FEAT);
    localparam int CNT_W = $clog2(N_FEAT + 1);
    localparam int DW    = FEAT_W + 1;
    localparam int SQ_W  = 2 * FEAT_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state_reg;
    logic [CNT_W-1:0]          count_reg;
    logic [3:0]                w_reg;
    logic [F_W-1:0]            f_reg;
    logic signed [FEAT_W-1:0]  feat_mem [N_FEAT];

    logic                      feat_accept;
    logic                      start_fire;
    logic                      issue;
    logic [3:0]                cur_w;
    logic [F_W-1:0]            cur_f;
    logic                      last_f;
    logic                      last_w;
    logic [ADDR_W-1:0]         cur_addr;

    // S0 / alignment / S1 pipeline registers
    logic signed [FEAT_W-1:0]  feat_s0_reg;
    logic                      s0_valid_reg, s0_last_reg;
    logic [3:0]                s0_word_reg;
    logic signed [FEAT_W-1:0]  feat_d_reg;
    logic                      d_valid_reg, d_last_reg;
    logic [3:0]                d_word_reg;
    logic [SQ_W-1:0]           sq_reg;
    logic                      s1_valid_reg, s1_last_reg;
    logic [3:0]                s1_word_reg;
    logic [63:0]               acc_reg;

    logic signed [DW-1:0]      diff;
    logic [SQ_W-1:0]           sq_next;
    logic [63:0]               sq_ext;

    assign ifeat_ready = (state_reg == IDLE) && (count_reg < CNT_W'(N_FEAT));
    assign feat_accept = ifeat_valid && ifeat_ready;
    assign start_fire  = (state_reg == IDLE) && istart && (count_reg == CNT_W'(N_FEAT));
    assign issue       = start_fire || (state_reg == RUN);
    // The start cycle issues (0,0) directly so the first address appears one cycle after istart.
    assign cur_w       = start_fire ? 4'd0 : w_reg;
    assign cur_f       = start_fire ? '0 : f_reg;
    assign last_f      = (cur_f == F_W'(N_FEAT - 1));
    assign last_w      = (cur_w == 4'(N_WORDS - 1));
    assign cur_addr    = ADDR_W'(cur_w) * ADDR_W'(N_FEAT) + ADDR_W'(cur_f);
    assign obusy       = (state_reg != IDLE);

    always_ff @(posedge iclk) begin
        if (feat_accept)
            feat_mem[count_reg[F_W-1:0]] <= ifeat;
    end

    always_ff @(posedge iclk) begin
        if (issue)
            feat_s0_reg <= feat_mem[cur_f];
    end

    // The template ROM has one cycle of read latency, so the feature waits one stage to meet it.
    assign diff = DW'(feat_d_reg) - DW'(itmpl_data);

`ifdef EUCLID_MANHATTAN_EN
    logic [DW-1:0] mag;
    assign mag     = diff[DW-1] ? DW'(-diff) : DW'(diff);
    assign sq_next = SQ_W'(mag);
`else
    logic signed [SQ_W-1:0] prod;
    assign prod    = SQ_W'(diff) * SQ_W'(diff);
    assign sq_next = prod;
`endif

    assign sq_ext = 64'(sq_reg);

    always_ff @(posedge iclk) begin
        if (!irstn) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            w_reg        <= '0;
            f_reg        <= '0;
            otmpl_addr   <= '0;
            s0_valid_reg <= 1'b0;
            s0_last_reg  <= 1'b0;
            s0_word_reg  <= '0;
            d_valid_reg  <= 1'b0;
            d_last_reg   <= 1'b0;
            d_word_reg   <= '0;
            feat_d_reg   <= '0;
            sq_reg       <= '0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_word_reg  <= '0;
            acc_reg      <= '0;
            oword        <= '0;
            odata        <= '0;
            ovalid       <= 1'b0;
            odone        <= 1'b0;
        end else begin
            odone  <= 1'b0;
            ovalid <= 1'b0;

            if (feat_accept)
                count_reg <= count_reg + 1'b1;

            s0_valid_reg <= issue;
            if (issue) begin
                otmpl_addr  <= cur_addr;
                s0_last_reg <= last_f;
                s0_word_reg <= cur_w;
                if (last_f) begin
                    f_reg <= '0;
                    w_reg <= cur_w + 4'd1;
                end else begin
                    f_reg <= cur_f + 1'b1;
                    w_reg <= cur_w;
                end
            end

            d_valid_reg  <= s0_valid_reg;
            d_last_reg   <= s0_last_reg;
            d_word_reg   <= s0_word_reg;
            feat_d_reg   <= feat_s0_reg;

            s1_valid_reg <= d_valid_reg;
            s1_last_reg  <= d_last_reg;
            s1_word_reg  <= d_word_reg;
            sq_reg       <= sq_next;

            if (s1_valid_reg) begin
                if (s1_last_reg) begin
                    odata   <= acc_reg + sq_ext;
                    oword   <= s1_word_reg;
                    ovalid  <= 1'b1;
                    acc_reg <= '0;
                end else begin
                    acc_reg <= acc_reg + sq_ext;
                end
            end

            case (state_reg)
                IDLE: if (start_fire) state_reg <= RUN;
                RUN: if (last_f && last_w) state_reg <= DRAIN;
                DRAIN: begin
                    if (ovalid && (oword == 4'(N_WORDS - 1))) begin
                        odone     <= 1'b1;
                        count_reg <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_euclidean_distance.sv
// Directed bench for euclidean_distance: ROM model, scoreboard queue of expected results.
module tb_euclidean_distance;
    localparam int NW = 3;
    localparam int NF = 4;
    localparam int FW = 16;
    localparam int AW = 4;

    logic                 iclk = 1'b0;
    logic                 irstn = 1'b0;
    logic signed [FW-1:0] ifeat = '0;
    logic                 ifeat_valid = 1'b0;
    logic                 ifeat_ready;
    logic                 istart = 1'b0;
    logic [AW-1:0]        otmpl_addr;
    logic signed [FW-1:0] itmpl_data;
    logic [3:0]           oword;
    logic [63:0]          odata;
    logic                 ovalid;
    logic                 obusy;
    logic                 odone;

    typedef struct {
        int          word;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t                 q[$];
    int                   n_tests = 0;
    int                   n_fail = 0;
    int                   cyc = 0;
    int                   t0 = 0;
    int                   exp_done = 0;
    bit                   sweep_active = 1'b0;
    bit                   done_seen = 1'b0;
    int                   mcount = 0;
    int                   fb[NF];
    logic [63:0]          exp_v[NW];
    logic signed [FW-1:0] rom[16];

    euclidean_distance #(.N_WORDS(NW), .N_FEAT(NF), .FEAT_W(FW), .ADDR_W(AW)) dut (
        .iclk        (iclk),
        .irstn       (irstn),
        .ifeat       (ifeat),
        .ifeat_valid (ifeat_valid),
        .ifeat_ready (ifeat_ready),
        .istart      (istart),
        .otmpl_addr  (otmpl_addr),
        .itmpl_data  (itmpl_data),
        .oword       (oword),
        .odata       (odata),
        .ovalid      (ovalid),
        .obusy       (obusy),
        .odone       (odone)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) begin
        cyc        <= cyc + 1;
        itmpl_data <= rom[otmpl_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input int w);
        longint s = 0;
        for (int i = 0; i < NF; i++) begin
            longint d = longint'(fb[i]) - longint'(rom[w*NF+i]);
`ifdef EUCLID_MANHATTAN_EN
            s += (d < 0) ? -d : d;
`else
            s += d * d;
`endif
        end
        return s;
    endfunction

    // Result / address / handshake monitor, sampled on the falling edge.
    always @(negedge iclk) begin : monitor_blk
        int   k;
        exp_t e;
        if (irstn) begin
            k = cyc - t0;
            if (sweep_active) begin
                if (k >= 1 && k <= NW*NF) chk("otmpl_addr", otmpl_addr, k - 1);
                if (k >= 1 && k <= NW*NF + 3) chk("obusy_run", obusy, 1);
            end
            if (ovalid) begin
                if (q.size() == 0) begin
                    chk("ovalid_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    $display("[TB] result word %0d data %0d cycle %0d", oword, odata, k);
                    chk("oword", oword, e.word);
                    chk("odata", odata, e.data);
                    chk("ovalid_cycle", cyc, e.cyc);
                end
            end
            if (odone) begin
                if (!sweep_active) begin
                    chk("odone_unexpected", 1, 0);
                end else begin
                    chk("odone_cycle", cyc, exp_done);
                    chk("odone_obusy", obusy, 0);
                end
                sweep_active = 1'b0;
                done_seen    = 1'b1;
            end
        end
    end

    task automatic feed(input int v);
        @(negedge iclk);
        ifeat       = FW'(v);
        ifeat_valid = 1'b1;
        chk("ifeat_ready", ifeat_ready, (mcount < NF) ? 1 : 0);
        if (mcount < NF) begin
            fb[mcount] = v;
            mcount++;
        end
    endtask

    task automatic feed_end();
        @(negedge iclk);
        ifeat_valid = 1'b0;
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        feed(a); feed(b); feed(c); feed(d);
        feed_end();
    endtask

    task automatic start_sweep();
        @(negedge iclk);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        t0 = cyc - 1;
        chk("obusy_start", obusy, 1);
        for (int w = 0; w < NW; w++)
            q.push_back('{w, exp_v[w], t0 + (w + 1)*NF + 3});
        exp_done     = t0 + NW*NF + 4;
        done_seen    = 1'b0;
        sweep_active = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_seen && n < 200) begin
            @(negedge iclk);
            n++;
        end
        chk("done_seen", done_seen, 1);
        chk("queue_empty", q.size(), 0);
        q.delete();
        mcount = 0;
    endtask

    task automatic set_model();
        for (int w = 0; w < NW; w++) exp_v[w] = model(w);
    endtask

    task automatic rom_basic();
        for (int i = 0; i < NF; i++) begin
            rom[i]        = FW'(i + 1);
            rom[NF + i]   = '0;
            rom[2*NF + i] = FW'(-(i + 1));
        end
    endtask

    initial begin : stim
        logic [AW-1:0] prev_addr;
        int            n;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom_basic();

        // Reset state
        repeat (3) @(negedge iclk);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_odone", odone, 0);
        chk("rst_obusy", obusy, 0);
        chk("rst_oword", oword, 0);
        chk("rst_odata", odata, 0);
        chk("rst_addr", otmpl_addr, 0);
        irstn = 1'b1;
        @(negedge iclk);
        chk("rst_ifeat_ready", ifeat_ready, 1);

        // Basic sweep with hand-derived results
        load4(1, 2, 3, 4);
`ifdef EUCLID_MANHATTAN_EN
        exp_v[0] = 64'd0; exp_v[1] = 64'd10; exp_v[2] = 64'd20;
`else
        exp_v[0] = 64'd0; exp_v[1] = 64'd30; exp_v[2] = 64'd120;
`endif
        start_sweep();
        wait_done();

        // Extremes
        for (int i = 0; i < NW*NF; i++) rom[i] = 16'sd32767;
        load4(-32768, -32768, -32768, -32768);
`ifdef EUCLID_MANHATTAN_EN
        for (int w = 0; w < NW; w++) exp_v[w] = 64'd262140;
`else
        for (int w = 0; w < NW; w++) exp_v[w] = 64'd17179344900;
`endif
        start_sweep();
        wait_done();

        // istart with a partial vector is ignored, also when the last sample lands in the same cycle
        rom_basic();
        feed(3); feed(-1); feed(2);
        feed_end();
        prev_addr = otmpl_addr;
        @(negedge iclk);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        chk("partial_obusy", obusy, 0);
        chk("partial_addr", otmpl_addr, prev_addr);
        ifeat       = 16'sd7;
        ifeat_valid = 1'b1;
        istart      = 1'b1;
        chk("last_sample_ready", ifeat_ready, 1);
        fb[3] = 7;
        mcount++;
        @(negedge iclk);
        ifeat_valid = 1'b0;
        istart      = 1'b0;
        chk("same_cycle_obusy", obusy, 0);
        chk("full_ready_low", ifeat_ready, 0);
        set_model();
        start_sweep();
        wait_done();

        // Valid held for 6 cycles: only 4 accepted; istart during RUN ignored
        feed(5); feed(-6); feed(7); feed(-8); feed(9); feed(-10);
        feed_end();
        set_model();
        start_sweep();
        repeat (3) @(negedge iclk);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        wait_done();

        // Reset in the middle of a sweep
        load4(10, 20, 30, 40);
        set_model();
        start_sweep();
        n = 0;
        while (cyc != t0 + 9 && n < 50) begin
            @(negedge iclk);
            n++;
        end
        chk("reach_cycle9", cyc - t0, 9);
        irstn        = 1'b0;
        sweep_active = 1'b0;
        q.delete();
        @(negedge iclk);
        irstn = 1'b1;
        chk("abort_obusy", obusy, 0);
        chk("abort_ready", ifeat_ready, 1);
        chk("abort_ovalid", ovalid, 0);
        mcount = 0;
        repeat (20) @(negedge iclk);
        load4(10, 20, 30, 40);
        start_sweep();
        wait_done();

        // Back-to-back sweep with identical vector: same results, accumulator restarts at 0
        load4(10, 20, 30, 40);
        start_sweep();
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
